// File: rtl/fif_rd_burst_pkg.sv
// Shared definitions for the FIFO read-side burst consumer.
// State encodings, GAP length and default data/address widths.
package fif_rd_burst_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam int GAP_LEN     = 2;
  localparam int SKID_DEPTH  = 2;
  localparam int KUAN_DEF    = 16;
  localparam int SHENBIT_DEF = 11;

endpackage

// File: rtl/fif_rd_burst_skid2.sv
// Two-entry registered buffer carrying {eop,sop,data} with valid/ready on both sides.
// Entry 0 is always the head; entry 1 holds the word behind it.
module fif_rd_burst_skid2
  import fif_rd_burst_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem0_q, mem1_q;
  logic [1:0]   cnt_q;
  logic         push, pop;

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem0_q;
  assign occ_o       = cnt_q;
  assign in_ready_o  = (cnt_q != 2'(SKID_DEPTH)) || out_ready_i;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: storage is cleared too, so dout reads 0 straight after reset.
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) mem0_q <= in_data_i;
          else               mem1_q <= in_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          mem0_q <= mem1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            mem0_q <= in_data_i;
          end else begin
            mem0_q <= mem1_q;
            mem1_q <= in_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fif_rd_burst.sv
// Read-side consumer of the dual-clock FIFO: issues credit-limited reads, emits fixed-length bursts.
// Optional idle-timeout flush of partial data is enabled by defining FIF_RD_TIMEOUT_EN.
module fif_rd_burst
  import fif_rd_burst_pkg::*;
#(
  parameter int kuan    = KUAN_DEF,
  parameter int shenbit = SHENBIT_DEF,
  parameter int blen    = 8,
  parameter int tmo     = 255
) (
  input  logic               rdclk,
  input  logic               aclr,
  output logic               fifo_rdreq,
  input  logic [kuan-1:0]    fifo_q,
  input  logic               fifo_rdempty,
  input  logic [shenbit-1:0] fifo_rdusedw,
  output logic [kuan-1:0]    dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_sop,
  output logic               dout_eop,
  output logic               busy
);

  if (blen < 1 || blen > 2**shenbit - 1 || tmo < 1) begin : g_bad_cfg
    $error("fif_rd_burst: blen or tmo out of range");
  end

  localparam logic [shenbit-1:0] BLEN_W = shenbit'(blen);
  localparam logic [shenbit-1:0] ONE_W  = shenbit'(1);

  state_e             state_q, state_d;
  logic [shenbit-1:0] remain_q, remain_d;
  logic               first_q, first_d;
  logic [1:0]         gap_q, gap_d;
  logic               inflight_q, sop_tag_q, eop_tag_q;

  logic [1:0]         occ;
  logic               skid_in_ready, pop, credit_ok;
  logic [kuan+1:0]    skid_out;

  assign pop       = dout_valid && dout_ready;
  // Words already buffered plus the one returning this cycle, minus the one leaving.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign fifo_rdreq = (state_q == S_BURST) && (remain_q != '0) && credit_ok;
  assign busy       = (state_q != S_IDLE);

`ifdef FIF_RD_TIMEOUT_EN
  localparam int TW = (tmo < 2) ? 1 : $clog2(tmo + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_run, tmo_hit;

  assign tmo_run = (state_q == S_IDLE) && (fifo_rdusedw != '0) && (fifo_rdusedw < BLEN_W);
  assign tmo_hit = tmo_run && !fifo_rdempty && (tmo_q == TW'(tmo));

  always_ff @(posedge rdclk) begin
    if (aclr || !tmo_run || tmo_hit) tmo_q <= '0;
    else if (tmo_q != TW'(tmo))      tmo_q <= tmo_q + TW'(1);
  end
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no latch is inferred.
    state_d  = state_q;
    remain_d = remain_q;
    first_d  = first_q;
    gap_d    = gap_q;
    unique case (state_q)
      S_IDLE: begin
        gap_d = 2'd0;
        if (fifo_rdusedw >= BLEN_W && !fifo_rdempty) begin
          remain_d = BLEN_W;
          first_d  = 1'b1;
          state_d  = S_BURST;
        end
`ifdef FIF_RD_TIMEOUT_EN
        else if (tmo_hit) begin
          remain_d = fifo_rdusedw;
          first_d  = 1'b1;
          state_d  = S_BURST;
        end
`endif
      end
      S_BURST: begin
        if (fifo_rdreq) begin
          remain_d = remain_q - ONE_W;
          first_d  = 1'b0;
        end
        if (remain_q == '0 && !inflight_q) state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + 2'd1;
        if (gap_q == 2'(GAP_LEN - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rdclk) begin
    if (aclr) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q    <= S_IDLE;
      remain_q   <= '0;
      first_q    <= 1'b0;
      gap_q      <= 2'd0;
      inflight_q <= 1'b0;
      sop_tag_q  <= 1'b0;
      eop_tag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      first_q    <= first_d;
      gap_q      <= gap_d;
      inflight_q <= fifo_rdreq;
      sop_tag_q  <= fifo_rdreq && first_q;
      eop_tag_q  <= fifo_rdreq && (remain_q == ONE_W);
    end
  end

  // The credit check guarantees a returning word always finds room.
  always_ff @(posedge rdclk) begin
    if (!aclr && inflight_q) assert (skid_in_ready);
  end

  fif_rd_burst_skid2 #(.W(kuan + 2)) u_skid (
    .clk_i      (rdclk),
    .rst_i      (aclr),
    .in_valid_i (inflight_q),
    .in_ready_o (skid_in_ready),
    .in_data_i  ({eop_tag_q, sop_tag_q, fifo_q}),
    .out_valid_o(dout_valid),
    .out_ready_i(dout_ready),
    .out_data_o (skid_out),
    .occ_o      (occ)
  );

  assign dout     = skid_out[kuan-1:0];
  assign dout_sop = dout_valid && skid_out[kuan];
  assign dout_eop = dout_valid && skid_out[kuan+1];

endmodule

// File: tb/tb_fif_rd_burst.sv
// Directed bench for fif_rd_burst: FIFO models with registered status, scoreboard of {eop,sop,data}.
// Instance u_dut0 uses blen=8, u_dut1 uses blen=1.
module tb_fif_rd_burst;

  logic clk = 1'b0;
  logic aclr = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT 0 (blen = 8) ----------------
  logic        rdreq0, empty0 = 1'b1, valid0, ready0 = 1'b1, sop0, eop0, busy0;
  logic        force_empty0 = 1'b0;
  logic [15:0] q0 = '0, dout0;
  logic [10:0] usedw0 = '0;
  logic [15:0] fq0[$];
  logic [17:0] sb0[$];
  int          beat_cyc0[$];
  int          rdreq_cnt0 = 0;

  fif_rd_burst #(.kuan(16), .shenbit(11), .blen(8), .tmo(255)) u_dut0 (
    .rdclk(clk), .aclr(aclr), .fifo_rdreq(rdreq0), .fifo_q(q0), .fifo_rdempty(empty0),
    .fifo_rdusedw(usedw0), .dout(dout0), .dout_valid(valid0), .dout_ready(ready0),
    .dout_sop(sop0), .dout_eop(eop0), .busy(busy0)
  );

  always @(posedge clk) begin
    if (rdreq0) begin
      rdreq_cnt0++;
      check("fifo0_underflow", 32'(fq0.size() != 0), 32'd1);
      if (fq0.size() != 0) q0 <= fq0.pop_front();
    end
    usedw0 <= 11'(fq0.size());
    empty0 <= force_empty0 || (fq0.size() == 0);
  end

  logic        hold0 = 1'b0;
  logic [18:0] held0 = '0;
  always @(negedge clk) begin
    if (aclr) begin
      hold0 = 1'b0;
    end else begin
      if (hold0) check("stall_stable0", 32'({valid0, eop0, sop0, dout0}), 32'(held0));
      if (valid0 && ready0) begin
        beat_cyc0.push_back(cyc);
        check("beat0", 32'({eop0, sop0, dout0}),
              32'((sb0.size() != 0) ? sb0.pop_front() : 18'h3FFFF));
      end
      hold0 = valid0 && !ready0;
      held0 = {valid0, eop0, sop0, dout0};
    end
  end

  task automatic load0(input int n, input int bl, input bit track, input int base);
    for (int i = 0; i < n; i++) begin
      fq0.push_back(16'(base + i));
      if (track) sb0.push_back({(i % bl) == bl - 1, (i % bl) == 0, 16'(base + i)});
    end
  endtask

  task automatic drain0(input int budget, input bit toggle, input string tag);
    int n = 0;
    while ((sb0.size() != 0 || busy0 || valid0) && n < budget) begin
      tick();
      if (toggle) ready0 = ~ready0;
      n++;
    end
    ready0 = 1'b1;
    check(tag, 32'(n < budget), 32'd1);
  endtask

  // ---------------- DUT 1 (blen = 1) ----------------
  logic        rdreq1, empty1 = 1'b1, valid1, sop1, eop1, busy1;
  logic        ready1 = 1'b1;
  logic [15:0] q1 = '0, dout1;
  logic [10:0] usedw1 = '0;
  logic [15:0] fq1[$];
  logic [17:0] sb1[$];
  int          beat_cyc1[$];
  int          rdreq_cnt1 = 0;

  fif_rd_burst #(.kuan(16), .shenbit(11), .blen(1), .tmo(255)) u_dut1 (
    .rdclk(clk), .aclr(aclr), .fifo_rdreq(rdreq1), .fifo_q(q1), .fifo_rdempty(empty1),
    .fifo_rdusedw(usedw1), .dout(dout1), .dout_valid(valid1), .dout_ready(ready1),
    .dout_sop(sop1), .dout_eop(eop1), .busy(busy1)
  );

  always @(posedge clk) begin
    if (rdreq1) begin
      rdreq_cnt1++;
      check("fifo1_underflow", 32'(fq1.size() != 0), 32'd1);
      if (fq1.size() != 0) q1 <= fq1.pop_front();
    end
    usedw1 <= 11'(fq1.size());
    empty1 <= (fq1.size() == 0);
  end

  always @(negedge clk) begin
    if (!aclr && valid1 && ready1) begin
      beat_cyc1.push_back(cyc);
      check("beat1", 32'({eop1, sop1, dout1}),
            32'((sb1.size() != 0) ? sb1.pop_front() : 18'h3FFFF));
    end
  end

  // ---------------- Directed sequence ----------------
  initial begin
    int rc, n, k, delay;

    repeat (3) tick();
    check("rst_rdreq", 32'(rdreq0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_sop",   32'(sop0),   32'd0);
    check("rst_eop",   32'(eop0),   32'd0);
    check("rst_busy",  32'(busy0),  32'd0);
    check("rst_dout",  32'(dout0),  32'd0);
    aclr = 1'b0;
    tick();

    // 1: eight words, ready held high
    rc = rdreq_cnt0;
    beat_cyc0.delete();
    load0(8, 8, 1'b1, 1);
    drain0(200, 1'b0, "t1_drain");
    check("t1_rdreq",  32'(rdreq_cnt0 - rc), 32'd8);
    check("t1_beats",  32'(beat_cyc0.size()), 32'd8);
    check("t1_no_bubble", 32'((beat_cyc0.size() >= 8) ? beat_cyc0[7] - beat_cyc0[0] : 0), 32'd7);

    // 2: sixteen words, ready toggling
    rc = rdreq_cnt0;
    load0(16, 8, 1'b1, 1);
    drain0(400, 1'b1, "t2_drain");
    check("t2_rdreq", 32'(rdreq_cnt0 - rc), 32'd16);

    // 3: five words, partial burst
    rc = rdreq_cnt0;
`ifdef FIF_RD_TIMEOUT_EN
    load0(5, 5, 1'b1, 1);
    n = 0;
    while (rdreq_cnt0 == rc && n < 400) begin
      tick();
      n++;
    end
    delay = n;
    check("t3_tmo_delay", 32'(delay >= 255 && delay <= 262), 32'd1);
    drain0(100, 1'b0, "t3_drain");
    check("t3_rdreq", 32'(rdreq_cnt0 - rc), 32'd5);
`else
    load0(5, 8, 1'b0, 1);
    repeat (1000) tick();
    check("t3_no_rdreq", 32'(rdreq_cnt0 - rc), 32'd0);
    check("t3_idle",     32'(busy0), 32'd0);
    fq0.delete();
    repeat (3) tick();
`endif

    // 5: rdusedw==blen but rdempty stuck high
    rc = rdreq_cnt0;
    force_empty0 = 1'b1;
    load0(8, 8, 1'b1, 16'h0040);
    repeat (20) tick();
    check("t5_held_rdreq", 32'(rdreq_cnt0 - rc), 32'd0);
    check("t5_held_busy",  32'(busy0), 32'd0);
    force_empty0 = 1'b0;
    drain0(200, 1'b0, "t5_drain");
    check("t5_rdreq", 32'(rdreq_cnt0 - rc), 32'd8);

    // 4: reset one cycle after the 3rd beat of a burst
    load0(16, 8, 1'b1, 16'h0080);
    rc = beat_cyc0.size();
    n = 0;
    while (beat_cyc0.size() < rc + 3 && n < 100) begin
      tick();
      n++;
    end
    check("t4_three_beats", 32'(n < 100), 32'd1);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    check("t4_rst_valid", 32'(valid0), 32'd0);
    check("t4_rst_sop",   32'(sop0),   32'd0);
    check("t4_rst_eop",   32'(eop0),   32'd0);
    check("t4_rst_busy",  32'(busy0),  32'd0);
    check("t4_rst_rdreq", 32'(rdreq0), 32'd0);
    check("t4_rst_dout",  32'(dout0),  32'd0);
    // words already read are lost; the rest of the FIFO forms fresh bursts
    sb0.delete();
    k = (8 - (fq0.size() % 8)) % 8;
    for (int i = 0; i < k; i++) fq0.push_back(16'(16'h0100 + i));
    for (int i = 0; i < fq0.size(); i++) sb0.push_back({(i % 8) == 7, (i % 8) == 0, fq0[i]});
    drain0(300, 1'b0, "t4_drain");

    // 6: blen=1, three single-beat bursts
    beat_cyc1.delete();
    for (int i = 0; i < 3; i++) begin
      fq1.push_back(16'(16'h0A00 + i));
      sb1.push_back({1'b1, 1'b1, 16'(16'h0A00 + i)});
    end
    n = 0;
    while ((sb1.size() != 0 || busy1) && n < 200) begin
      tick();
      n++;
    end
    check("t6_drain", 32'(n < 200), 32'd1);
    check("t6_rdreq", 32'(rdreq_cnt1), 32'd3);
    check("t6_beats", 32'(beat_cyc1.size()), 32'd3);
    check("t6_gap01", 32'((beat_cyc1.size() >= 3) && (beat_cyc1[1] - beat_cyc1[0] >= 3)), 32'd1);
    check("t6_gap12", 32'((beat_cyc1.size() >= 3) && (beat_cyc1[2] - beat_cyc1[1] >= 3)), 32'd1);

    check("end_sb0_empty", 32'(sb0.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
